bp_fe_bp_gshare: RTL and testbench
==================================

# bp_fe_bp_gshare

Global-history (gshare) direction predictor for the front end: the parametrised successor of the bimodal BHT. It XORs the branch index with a speculative global history register (GHR) to select an N-bit saturating counter, registers the prediction for one cycle, and trains on resolved outcomes. On a mispredict it repairs the GHR from the history snapshot returned with the update. It sits between the fetch-PC index logic and the branch-resolution return path.

## Interface
- bht_idx_width_p, "inv", log2 of table entries; must be overridden.
- ghist_width_p, 8, GHR width; 1 <= ghist_width_p <= bht_idx_width_p.
- bp_cnt_sat_bits_p, 2, counter width; >= 2.
- cnt_width_p, 32, width of each performance counter.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_i  in  1  synchronous, active-high reset.
- r_v_i  in  1  prediction request.
- idx_r_i  in  bht_idx_width_p  branch index for the request.
- predict_v_o  out  1  registered; high the cycle after an accepted r_v_i.
- predict_o  out  1  registered predicted direction; 1 = taken.
- ghist_o  out  ghist_width_p  registered GHR value used for this prediction; the caller returns it as ghist_w_i.
- w_v_i  in  1  resolved-branch update.
- idx_w_i  in  bht_idx_width_p  index of the resolved branch.
- ghist_w_i  in  ghist_width_p  history snapshot from that branch's prediction.
- taken_i  in  1  actual resolved direction.
- mispredict_i  in  1  qualified by w_v_i; prediction was wrong.
- pred_cnt_o  out  cnt_width_p  number of accepted predictions.
- mispred_cnt_o  out  cnt_width_p  number of w_v_i & mispredict_i events.

## Operation
- Hash: h(idx, g) = idx XOR zero-extended g, with g occupying the low ghist_width_p bits.
- Table: 2^bht_idx_width_p counters, each bp_cnt_sat_bits_p wide. Taken iff counter > 2^(N-1)-1, i.e. counter MSB = 1.
- Read: when r_v_i is high, the entry h(idx_r_i, GHR) is read combinationally. On the edge, predict_o gets the taken bit, ghist_o gets the current GHR, predict_v_o goes to 1, and GHR shifts to {GHR[w-2:0], predicted bit}. When r_v_i is low, predict_v_o goes to 0, predict_o and ghist_o hold, and GHR holds.
- Train: when w_v_i is high, entry h(idx_w_i, ghist_w_i) increments if taken_i = 1 and decrements if taken_i = 0.
  - Saturates at 2^N-1 and at 0; no wrap.
  - Training uses the outcome, not correctness.
- Repair: w_v_i & mispredict_i loads GHR with {ghist_w_i[w-2:0], taken_i}. This has priority over a same-cycle speculative shift from r_v_i. The prediction made in that cycle still uses the pre-repair GHR.
- Same-entry read/write in one cycle: the table write occurs. The read result depends on the macro; see Configuration.
- Performance counters:
  - pred_cnt_o increments on each r_v_i.
  - mispred_cnt_o increments on each w_v_i & mispredict_i.
  - Both saturate at all-ones.
- Reset: every counter goes to 2^(N-1)-1 (weakly not-taken). GHR = 0, predict_v_o = 0, predict_o = 0, ghist_o = 0, both perf counters = 0. r_v_i and w_v_i are ignored while reset_i is high. A prediction pending when reset rises is discarded (predict_v_o = 0 next cycle).

## Timing
- Prediction latency is 1 cycle: r_v_i in cycle t gives predict_v_o/predict_o/ghist_o valid in cycle t+1.
- Throughput is one prediction and one update per cycle, concurrently; no backpressure.
- A table update is visible to reads from cycle t+1 (cycle t with bypass).
- GHR speculation: back-to-back predictions in t and t+1 use GHR values differing by exactly one shifted-in bit.
- Repair in cycle t: a read in cycle t+1 hashes with the repaired GHR.

## Configuration
- BP_GSHARE_BYPASS_EN defined: if w_v_i and r_v_i target the same hashed entry in one cycle, predict_o reflects the post-update (saturated) counter value.
- Not defined: the read returns the pre-update value. The write still occurs.
- All other behaviour is identical with or without the macro.

## Test plan
- Reset defaults: assert reset_i with bp_cnt_sat_bits_p=2, then r_v_i idx 5 -> predict_v_o=1, predict_o=0, ghist_o=0; pred_cnt_o=1.
- Saturation: three w_v_i taken_i=1 updates to idx 3 with ghist_w_i=0, then a fourth -> counter stays 3 and read idx 3 with GHR=0 predicts 1. Four taken_i=0 updates -> counter 0, no wrap to 3.
- Speculative history: ghist_width_p=4; predictions taken,not-taken,taken from GHR=0 -> ghist_o sequence 0000, 0001, 0010; GHR ends 0101.
- Repair priority: w_v_i, mispredict_i, ghist_w_i=4'b0110, taken_i=1 in the same cycle as r_v_i predicting 0 -> next GHR=4'b1101; mispred_cnt_o increments by 1.
- Bypass: entry at 1, same-cycle taken_i=1 update and read of that entry -> predict_o=1 with BP_GSHARE_BYPASS_EN, 0 without.
- Reset mid-stream: reset_i high in the cycle after r_v_i -> predict_v_o=0 and the GHR, table and perf counters all return to reset values.

Source files
------------

// File: rtl/bp_fe_bp_gshare.sv
// Gshare direction predictor: (idx ^ GHR) selects a saturating counter; trains on resolved outcomes, repairs GHR on mispredict.
// Latency: prediction registered, valid one cycle after r_v_i; table updates visible to reads the next cycle.
// Backpressure: none; accepts one prediction and one update every cycle. Optional same-cycle write->read bypass via BP_GSHARE_BYPASS_EN.
module bp_fe_bp_gshare #(
    // Log2 of table entries; callers are expected to override this.
    parameter int bht_idx_width_p   = 8,
    parameter int ghist_width_p     = 8,
    parameter int bp_cnt_sat_bits_p = 2,
    parameter int cnt_width_p       = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] idx_r_i,
    output logic                       predict_v_o,
    output logic                       predict_o,
    output logic [ghist_width_p-1:0]   ghist_o,

    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] idx_w_i,
    input  logic [ghist_width_p-1:0]   ghist_w_i,
    input  logic                       taken_i,
    input  logic                       mispredict_i,

    output logic [cnt_width_p-1:0]     pred_cnt_o,
    output logic [cnt_width_p-1:0]     mispred_cnt_o
);

    localparam int entries_lp = 1 << bht_idx_width_p;
    // Weakly not-taken: MSB clear, all lower bits set.
    localparam logic [bp_cnt_sat_bits_p-1:0] cnt_init_lp = {1'b0, {(bp_cnt_sat_bits_p-1){1'b1}}};

    logic [bp_cnt_sat_bits_p-1:0] table_q [entries_lp];
    logic [ghist_width_p-1:0]     ghr_q;

    logic [bht_idx_width_p-1:0]   ghr_ext;
    logic [bht_idx_width_p-1:0]   ghist_w_ext;
    logic [bht_idx_width_p-1:0]   r_hash;
    logic [bht_idx_width_p-1:0]   w_hash;
    logic [bp_cnt_sat_bits_p-1:0] w_cnt_cur;
    logic [bp_cnt_sat_bits_p-1:0] w_cnt_nxt;
    logic [bp_cnt_sat_bits_p-1:0] r_cnt;
    logic                         r_taken;
    logic [ghist_width_p:0]       ghr_spec_wide;
    logic [ghist_width_p:0]       ghr_fix_wide;
    logic [ghist_width_p-1:0]     ghr_nxt;
    logic                         mispred_ev;

    // Hash both ports, compute the saturating update and the (optionally bypassed) read.
    always_comb begin
        ghr_ext                       = '0;
        ghr_ext[ghist_width_p-1:0]    = ghr_q;
        ghist_w_ext                   = '0;
        ghist_w_ext[ghist_width_p-1:0] = ghist_w_i;
        r_hash    = idx_r_i ^ ghr_ext;
        w_hash    = idx_w_i ^ ghist_w_ext;

        w_cnt_cur = table_q[w_hash];
        w_cnt_nxt = w_cnt_cur;
        if (taken_i && (w_cnt_cur != '1)) begin
            w_cnt_nxt = w_cnt_cur + 1'b1;
        end else if (!taken_i && (w_cnt_cur != '0)) begin
            w_cnt_nxt = w_cnt_cur - 1'b1;
        end

        r_cnt = table_q[r_hash];
`ifdef BP_GSHARE_BYPASS_EN
        if (w_v_i && (w_hash == r_hash)) begin
            r_cnt = w_cnt_nxt;
        end
`endif
        r_taken = r_cnt[bp_cnt_sat_bits_p-1];
    end

    // Next GHR: repair from the returned snapshot beats the speculative shift.
    always_comb begin
        mispred_ev    = w_v_i & mispredict_i;
        ghr_spec_wide = {ghr_q, r_taken};
        ghr_fix_wide  = {ghist_w_i, taken_i};
        ghr_nxt       = ghr_q;
        if (r_v_i) begin
            ghr_nxt = ghr_spec_wide[ghist_width_p-1:0];
        end
        if (mispred_ev) begin
            ghr_nxt = ghr_fix_wide[ghist_width_p-1:0];
        end
    end

    // Counter table: reset to weakly not-taken, then train on every resolved branch.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < entries_lp; i++) begin
                table_q[i] <= cnt_init_lp;
            end
        end else if (w_v_i) begin
            table_q[w_hash] <= w_cnt_nxt;
        end
    end

    // GHR and registered prediction outputs; outputs hold when no request.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ghr_q       <= '0;
            predict_v_o <= 1'b0;
            predict_o   <= 1'b0;
            ghist_o     <= '0;
        end else begin
            ghr_q       <= ghr_nxt;
            predict_v_o <= r_v_i;
            if (r_v_i) begin
                predict_o <= r_taken;
                ghist_o   <= ghr_q;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pred_cnt_o    <= '0;
            mispred_cnt_o <= '0;
        end else begin
            if (r_v_i && (pred_cnt_o != '1)) begin
                pred_cnt_o <= pred_cnt_o + 1'b1;
            end
            if (mispred_ev && (mispred_cnt_o != '1)) begin
                mispred_cnt_o <= mispred_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bp_fe_bp_gshare.sv
// Directed bench for bp_fe_bp_gshare with 16 entries, 4-bit GHR, 2-bit counters, 8-bit perf counters.
// Every scenario starts from reset so table contents and GHR are known.
// Expected values are hand-derived from the predictor's definition.
module tb_bp_fe_bp_gshare;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       r_v_i;
    logic [3:0] idx_r_i;
    logic       predict_v_o;
    logic       predict_o;
    logic [3:0] ghist_o;
    logic       w_v_i;
    logic [3:0] idx_w_i;
    logic [3:0] ghist_w_i;
    logic       taken_i;
    logic       mispredict_i;
    logic [7:0] pred_cnt_o;
    logic [7:0] mispred_cnt_o;

    int checks = 0;
    int errors = 0;
    logic exp_byp;

    bp_fe_bp_gshare #(
        .bht_idx_width_p  (4),
        .ghist_width_p    (4),
        .bp_cnt_sat_bits_p(2),
        .cnt_width_p      (8)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .r_v_i        (r_v_i),
        .idx_r_i      (idx_r_i),
        .predict_v_o  (predict_v_o),
        .predict_o    (predict_o),
        .ghist_o      (ghist_o),
        .w_v_i        (w_v_i),
        .idx_w_i      (idx_w_i),
        .ghist_w_i    (ghist_w_i),
        .taken_i      (taken_i),
        .mispredict_i (mispredict_i),
        .pred_cnt_o   (pred_cnt_o),
        .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one cycle and settle just after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        r_v_i = 0; idx_r_i = 0; w_v_i = 0; idx_w_i = 0;
        ghist_w_i = 0; taken_i = 0; mispredict_i = 0;
    endtask

    task automatic do_reset();
        idle();
        reset_i = 1;
        tick();
        tick();
        reset_i = 0;
    endtask

    task automatic upd(input logic [3:0] idx, input logic [3:0] g, input logic t);
        idle();
        w_v_i = 1; idx_w_i = idx; ghist_w_i = g; taken_i = t;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset_i = 1;
        r_v_i = 1; idx_r_i = 4'd5;
        w_v_i = 1; mispredict_i = 1; taken_i = 1;
        tick();
        tick();
        idle();
        reset_i = 0;
        checks++; if (predict_v_o !== 1'b0) begin errors++; $display("FAIL rst_pv got %0b want 0", predict_v_o); end
        checks++; if (predict_o !== 1'b0) begin errors++; $display("FAIL rst_pred got %0b want 0", predict_o); end
        checks++; if (ghist_o !== 4'd0) begin errors++; $display("FAIL rst_ghist got %b want 0000", ghist_o); end
        checks++; if (pred_cnt_o !== 8'd0) begin errors++; $display("FAIL rst_pcnt got %0d want 0", pred_cnt_o); end
        checks++; if (mispred_cnt_o !== 8'd0) begin errors++; $display("FAIL rst_mcnt got %0d want 0", mispred_cnt_o); end
        r_v_i = 1; idx_r_i = 4'd5;
        tick();
        r_v_i = 0;
        checks++; if (predict_v_o !== 1'b1) begin errors++; $display("FAIL first_pv got %0b want 1", predict_v_o); end
        checks++; if (predict_o !== 1'b0) begin errors++; $display("FAIL first_pred got %0b want 0", predict_o); end
        checks++; if (ghist_o !== 4'd0) begin errors++; $display("FAIL first_ghist got %b want 0000", ghist_o); end
        checks++; if (pred_cnt_o !== 8'd1) begin errors++; $display("FAIL first_pcnt got %0d want 1", pred_cnt_o); end
        tick();
        checks++; if (predict_v_o !== 1'b0) begin errors++; $display("FAIL idle_pv got %0b want 0", predict_v_o); end
    endtask

    task automatic test_saturation();
        do_reset();
        // 1 -> 2 -> 3 -> 3 -> 3
        for (int i = 0; i < 4; i++) upd(4'd3, 4'd0, 1'b1);
        r_v_i = 1; idx_r_i = 4'd3;
        tick();
        idle();
        checks++; if (predict_o !== 1'b1) begin errors++; $display("FAIL sat_hi got %0b want 1", predict_o); end
        // GHR now 0001. 3 -> 2 -> 1 -> 0 -> 0
        for (int i = 0; i < 4; i++) upd(4'd3, 4'd0, 1'b0);
        r_v_i = 1; idx_r_i = 4'd2;          // 2 ^ 0001 = entry 3
        tick();
        idle();
        checks++; if (predict_o !== 1'b0) begin errors++; $display("FAIL sat_lo got %0b want 0", predict_o); end
        checks++; if (ghist_o !== 4'b0001) begin errors++; $display("FAIL sat_lo_ghist got %b want 0001", ghist_o); end
        // GHR now 0010. One increment from 0 gives 1: still not taken.
        upd(4'd3, 4'd0, 1'b1);
        r_v_i = 1; idx_r_i = 4'd1;          // 1 ^ 0010 = entry 3
        tick();
        idle();
        checks++; if (predict_o !== 1'b0) begin errors++; $display("FAIL sat_floor got %0b want 0", predict_o); end
        checks++; if (ghist_o !== 4'b0010) begin errors++; $display("FAIL sat_floor_ghist got %b want 0010", ghist_o); end
    endtask

    task automatic test_spec_history();
        logic [3:0] idx_tab  [4];
        logic       pred_tab [4];
        logic [3:0] gh_tab   [4];
        do_reset();
        upd(4'd5, 4'd0, 1'b1);               // entry 5 -> 2
        upd(4'd9, 4'd0, 1'b1);               // entry 9 -> 2
        idx_tab[0] = 4'd5;  pred_tab[0] = 1; gh_tab[0] = 4'b0000; // entry 5
        idx_tab[1] = 4'd7;  pred_tab[1] = 0; gh_tab[1] = 4'b0001; // entry 6
        idx_tab[2] = 4'd11; pred_tab[2] = 1; gh_tab[2] = 4'b0010; // entry 9
        idx_tab[3] = 4'd0;  pred_tab[3] = 1; gh_tab[3] = 4'b0101; // entry 5
        for (int i = 0; i < 4; i++) begin
            r_v_i = 1; idx_r_i = idx_tab[i];
            tick();
            checks++; if (predict_v_o !== 1'b1) begin errors++; $display("FAIL hist_pv[%0d] got %0b want 1", i, predict_v_o); end
            checks++; if (predict_o !== pred_tab[i]) begin errors++; $display("FAIL hist_pred[%0d] got %0b want %0b", i, predict_o, pred_tab[i]); end
            checks++; if (ghist_o !== gh_tab[i]) begin errors++; $display("FAIL hist_ghist[%0d] got %b want %b", i, ghist_o, gh_tab[i]); end
        end
        idle();
    endtask

    task automatic test_repair();
        do_reset();
        r_v_i = 1; idx_r_i = 4'd0;                          // entry 0 -> predicts 0
        w_v_i = 1; mispredict_i = 1; idx_w_i = 4'd2; ghist_w_i = 4'b0110; taken_i = 1; // entry 4 -> 2
        tick();
        idle();
        checks++; if (predict_o !== 1'b0) begin errors++; $display("FAIL rep_pred got %0b want 0", predict_o); end
        checks++; if (ghist_o !== 4'b0000) begin errors++; $display("FAIL rep_pre_ghist got %b want 0000", ghist_o); end
        checks++; if (mispred_cnt_o !== 8'd1) begin errors++; $display("FAIL rep_mcnt got %0d want 1", mispred_cnt_o); end
        // Unqualified mispredict must be ignored.
        r_v_i = 1; idx_r_i = 4'd0; mispredict_i = 1; ghist_w_i = 4'b1111; taken_i = 1;
        tick();
        idle();
        checks++; if (ghist_o !== 4'b1101) begin errors++; $display("FAIL rep_ghist got %b want 1101", ghist_o); end
        checks++; if (mispred_cnt_o !== 8'd1) begin errors++; $display("FAIL rep_mcnt_unq got %0d want 1", mispred_cnt_o); end
        r_v_i = 1; idx_r_i = 4'd14;                         // 14 ^ 1010 = entry 4
        tick();
        idle();
        checks++; if (ghist_o !== 4'b1010) begin errors++; $display("FAIL rep_ghist2 got %b want 1010", ghist_o); end
        checks++; if (predict_o !== 1'b1) begin errors++; $display("FAIL rep_train got %0b want 1", predict_o); end
    endtask

    task automatic test_bypass();
`ifdef BP_GSHARE_BYPASS_EN
        exp_byp = 1'b1;
`else
        exp_byp = 1'b0;
`endif
        do_reset();
        r_v_i = 1; idx_r_i = 4'd1;
        w_v_i = 1; idx_w_i = 4'd1; ghist_w_i = 4'd0; taken_i = 1;
        tick();
        idle();
        checks++; if (predict_o !== exp_byp) begin errors++; $display("FAIL byp_pred got %0b want %0b", predict_o, exp_byp); end
        // Write landed either way: entry 1 now 2.
        r_v_i = 1; idx_r_i = {3'b000, ~exp_byp};
        tick();
        idle();
        checks++; if (predict_o !== 1'b1) begin errors++; $display("FAIL byp_write got %0b want 1", predict_o); end
        checks++; if (ghist_o !== {3'b000, exp_byp}) begin errors++; $display("FAIL byp_ghist got %b want %b", ghist_o, {3'b000, exp_byp}); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        w_v_i = 1; mispredict_i = 1; idx_w_i = 4'd3; ghist_w_i = 4'd0; taken_i = 1; // entry 3 -> 2, GHR 0001
        tick();
        idle();
        r_v_i = 1; idx_r_i = 4'd2;                          // 2 ^ 0001 = entry 3
        tick();
        checks++; if (predict_o !== 1'b1 || ghist_o !== 4'b0001) begin errors++; $display("FAIL mid_pre got %0b/%b want 1/0001", predict_o, ghist_o); end
        reset_i = 1;
        w_v_i = 1; mispredict_i = 1; idx_w_i = 4'd3; taken_i = 1;
        tick();
        reset_i = 0;
        idle();
        checks++; if (predict_v_o !== 1'b0) begin errors++; $display("FAIL mid_pv got %0b want 0", predict_v_o); end
        checks++; if (predict_o !== 1'b0 || ghist_o !== 4'd0) begin errors++; $display("FAIL mid_outs got %0b/%b want 0/0000", predict_o, ghist_o); end
        checks++; if (pred_cnt_o !== 8'd0 || mispred_cnt_o !== 8'd0) begin errors++; $display("FAIL mid_cnts got %0d/%0d want 0/0", pred_cnt_o, mispred_cnt_o); end
        r_v_i = 1; idx_r_i = 4'd3;                          // GHR 0 -> entry 3, back to 1
        tick();
        idle();
        checks++; if (predict_o !== 1'b0) begin errors++; $display("FAIL mid_table got %0b want 0", predict_o); end
        checks++; if (ghist_o !== 4'd0) begin errors++; $display("FAIL mid_ghr got %b want 0000", ghist_o); end
        checks++; if (pred_cnt_o !== 8'd1) begin errors++; $display("FAIL mid_pcnt got %0d want 1", pred_cnt_o); end
    endtask

    task automatic test_cnt_sat();
        do_reset();
        r_v_i = 1; idx_r_i = 4'd0;
        for (int i = 0; i < 254; i++) tick();
        checks++; if (pred_cnt_o !== 8'd254) begin errors++; $display("FAIL pcnt_254 got %0d want 254", pred_cnt_o); end
        for (int i = 0; i < 6; i++) tick();
        idle();
        checks++; if (pred_cnt_o !== 8'd255) begin errors++; $display("FAIL pcnt_sat got %0d want 255", pred_cnt_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset_i = 1;
        test_reset();
        test_saturation();
        test_spec_history();
        test_repair();
        test_bypass();
        test_reset_midstream();
        test_cnt_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
